// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  // Multi-cycle (mul/div) sequencer states.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand source select driven to the ID/EX operand muxes.
  localparam logic [1:0] FWD_REG = 2'b00;  // register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM result
  localparam logic [1:0] FWD_EX  = 2'b10;  // ALU result in EX
  localparam logic [1:0] FWD_WB  = 2'b11;  // MEM/WB result

endpackage

// File: rtl/hz_fwd_sel.sv
// Forwarding source selection for one decode-stage operand.
// The youngest producer wins (EX > MEM > WB). A load still in EX has no
// data yet, so it is skipped here and the load-use stall covers the gap.
module hz_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic [REG_AW-1:0] e_rd,
  input  logic              e_wreg,
  input  logic              e_load,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_wreg,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_wreg,
  output logic [1:0]        fwd,
  output logic              e_match
);

  logic live;
  logic m_match;
  logic w_match;

  // An operand is a forwarding candidate only if it is really read and is
  // not the hard-wired zero register.
  assign live    = use_src && (src != '0);
  assign e_match = live && e_wreg && (src == e_rd);
  assign m_match = live && m_wreg && (src == m_rd);
  assign w_match = live && w_wreg && (src == w_rd);

  // Priority select of the operand source.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch
    // is inferred when none of the branches below is taken.
    fwd = FWD_REG;
    if (e_match && !e_load) begin
      fwd = FWD_EX;
    end else if (m_match) begin
      fwd = FWD_MEM;
    end else if (w_match) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// multi-cycle (mul/div) stall sequencing, branch flush and a saturating
// stall-cycle performance counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] D_Rs,
  input  logic [REG_AW-1:0] D_Rt,
  input  logic              D_UseRs,
  input  logic              D_UseRt,
  input  logic [REG_AW-1:0] E_Rd,
  input  logic [REG_AW-1:0] M_Rd,
  input  logic [REG_AW-1:0] W_Rd,
  input  logic              E_Wreg,
  input  logic              M_Wreg,
  input  logic              W_Wreg,
  input  logic              E_Load,
  input  logic              E_Mdu,
  input  logic              M_Taken,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic              Stall,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              MduDone,
  output logic [CNT_W-1:0]  StallCnt
);

  // Down-counter just wide enough to hold MDU_LAT-1.
  localparam int MDU_CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [MDU_CW-1:0] cnt;
  logic [MDU_CW-1:0] cnt_nxt;
  logic              fsm_stall;
  logic              rs_e_match;
  logic              rt_e_match;
  logic              ld_use;

  hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs (
    .src     (D_Rs),
    .use_src (D_UseRs),
    .e_rd    (E_Rd),
    .e_wreg  (E_Wreg),
    .e_load  (E_Load),
    .m_rd    (M_Rd),
    .m_wreg  (M_Wreg),
    .w_rd    (W_Rd),
    .w_wreg  (W_Wreg),
    .fwd     (FwdA),
    .e_match (rs_e_match)
  );

  hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rt (
    .src     (D_Rt),
    .use_src (D_UseRt),
    .e_rd    (E_Rd),
    .e_wreg  (E_Wreg),
    .e_load  (E_Load),
    .m_rd    (M_Rd),
    .m_wreg  (M_Wreg),
    .w_rd    (W_Rd),
    .w_wreg  (W_Wreg),
    .fwd     (FwdB),
    .e_match (rt_e_match)
  );

  // A load in EX feeding a decode operand must hold decode for one cycle;
  // the load then sits in MEM and normal forwarding takes over.
  assign ld_use = E_Load && E_Wreg && (E_Rd != '0) && (rs_e_match || rt_e_match);

  // Multi-cycle sequencer: the RUN acceptance cycle plus MDU_LAT-1 BUSY
  // cycles give exactly MDU_LAT stall cycles, then one DONE cycle. A taken
  // branch squashes the younger op in EX, so BUSY is abandoned silently.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fsm_stall = 1'b0;
    case (state)
      RUN: begin
        if (E_Mdu && !M_Taken) begin
          fsm_stall = 1'b1;
          cnt_nxt   = MDU_CW'(MDU_LAT - 1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (M_Taken) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          fsm_stall = 1'b1;
          cnt_nxt   = cnt - MDU_CW'(1);
          if (cnt == MDU_CW'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = RUN;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
    endcase
  end

  // Pipeline control outputs; the branch squash overrides every stall, and
  // the sequencer's stall is masked while reset is held.
  assign Stall   = (ld_use || (fsm_stall && !Rst)) && !M_Taken;
  assign Flush_D = M_Taken;
  assign Flush_E = ld_use || M_Taken;
  assign MduDone = (state == DONE);

  // Sequencer state, down-counter and saturating stall counter.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (Rst) begin
      state    <= RUN;
      cnt      <= '0;
      StallCnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (Stall && (StallCnt != {CNT_W{1'b1}})) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of combinational forwarding and
// load-use vectors, then hand-written multi-cycle sequences. A second
// instance with a 3-bit stall counter exercises saturation.
module tb_hazard_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] d_rs, d_rt, e_rd, m_rd, w_rd;
  logic          d_use_rs, d_use_rt, e_wreg, m_wreg, w_wreg;
  logic          e_load, e_mdu, m_taken;

  logic [1:0]    fwd_a, fwd_b;
  logic          stall, flush_d, flush_e, mdu_done;
  logic [15:0]   stall_cnt;

  logic [1:0]    s_fwd_a, s_fwd_b;
  logic          s_stall, s_flush_d, s_flush_e, s_mdu_done;
  logic [2:0]    s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .MDU_LAT(4), .CNT_W(16)) dut (
    .Clk(clk), .Rst(rst),
    .D_Rs(d_rs), .D_Rt(d_rt), .D_UseRs(d_use_rs), .D_UseRt(d_use_rt),
    .E_Rd(e_rd), .M_Rd(m_rd), .W_Rd(w_rd),
    .E_Wreg(e_wreg), .M_Wreg(m_wreg), .W_Wreg(w_wreg),
    .E_Load(e_load), .E_Mdu(e_mdu), .M_Taken(m_taken),
    .FwdA(fwd_a), .FwdB(fwd_b), .Stall(stall),
    .Flush_D(flush_d), .Flush_E(flush_e), .MduDone(mdu_done),
    .StallCnt(stall_cnt)
  );

  hazard_ctrl #(.REG_AW(AW), .MDU_LAT(4), .CNT_W(3)) dut_sat (
    .Clk(clk), .Rst(rst),
    .D_Rs(d_rs), .D_Rt(d_rt), .D_UseRs(d_use_rs), .D_UseRt(d_use_rt),
    .E_Rd(e_rd), .M_Rd(m_rd), .W_Rd(w_rd),
    .E_Wreg(e_wreg), .M_Wreg(m_wreg), .W_Wreg(w_wreg),
    .E_Load(e_load), .E_Mdu(e_mdu), .M_Taken(m_taken),
    .FwdA(s_fwd_a), .FwdB(s_fwd_b), .Stall(s_stall),
    .Flush_D(s_flush_d), .Flush_E(s_flush_e), .MduDone(s_mdu_done),
    .StallCnt(s_stall_cnt)
  );

  typedef struct {
    logic [AW-1:0] rs, rt, erd, mrd, wrd;
    logic          urs, urt, ewr, eld, mwr, wwr, mt;
    logic [1:0]    fa, fb;
    logic          st, fd, fe;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic [AW-1:0] rs, input logic urs, input logic [AW-1:0] rt, input logic urt,
    input logic [AW-1:0] erd, input logic ewr, input logic eld,
    input logic [AW-1:0] mrd, input logic mwr, input logic [AW-1:0] wrd, input logic wwr,
    input logic mt, input logic [1:0] fa, input logic [1:0] fb,
    input logic st, input logic fd, input logic fe);
    vec_t v;
    v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.erd = erd; v.ewr = ewr; v.eld = eld;
    v.mrd = mrd; v.mwr = mwr; v.wrd = wrd; v.wwr = wwr; v.mt = mt;
    v.fa = fa; v.fb = fb; v.st = st; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    d_rs = '0; d_rt = '0; e_rd = '0; m_rd = '0; w_rd = '0;
    d_use_rs = 0; d_use_rt = 0; e_wreg = 0; m_wreg = 0; w_wreg = 0;
    e_load = 0; e_mdu = 0; m_taken = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    e_load = 1; e_rd = 5; e_wreg = 1; d_rt = 5; d_use_rt = 1;
  endtask

  initial begin
    //            rs urs rt urt erd ewr eld mrd mwr wrd wwr mt  fa     fb    st fd fe
    vecs[0]  = mk(3, 1, 0, 0,  3, 1, 0,  3, 1,  0, 0,  0, 2'b10, 2'b00, 0, 0, 0);
    vecs[1]  = mk(3, 1, 0, 0,  3, 0, 0,  3, 1,  0, 0,  0, 2'b01, 2'b00, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0,  3, 1, 0,  3, 1,  0, 0,  0, 2'b00, 2'b00, 0, 0, 0);
    vecs[3]  = mk(7, 1, 0, 0,  0, 0, 0,  0, 0,  7, 1,  0, 2'b11, 2'b00, 0, 0, 0);
    vecs[4]  = mk(7, 0, 0, 0,  0, 0, 0,  0, 0,  7, 1,  0, 2'b00, 2'b00, 0, 0, 0);
    vecs[5]  = mk(3, 1, 0, 0,  0, 0, 0,  3, 0,  3, 1,  0, 2'b11, 2'b00, 0, 0, 0);
    vecs[6]  = mk(0, 0, 5, 1,  5, 1, 1,  5, 1,  0, 0,  0, 2'b00, 2'b01, 1, 0, 1);
    vecs[7]  = mk(0, 0, 5, 1,  5, 1, 1,  0, 0,  5, 1,  0, 2'b00, 2'b11, 1, 0, 1);
    vecs[8]  = mk(0, 0, 5, 0,  5, 1, 1,  0, 0,  0, 0,  0, 2'b00, 2'b00, 0, 0, 0);
    vecs[9]  = mk(0, 0, 5, 1,  5, 0, 1,  0, 0,  0, 0,  0, 2'b00, 2'b00, 0, 0, 0);
    vecs[10] = mk(0, 0, 5, 1,  5, 1, 1,  0, 0,  0, 0,  1, 2'b00, 2'b00, 0, 1, 1);
    vecs[11] = mk(2, 1, 2, 1,  0, 0, 0,  2, 1,  2, 1,  0, 2'b01, 2'b01, 0, 0, 0);
    vecs[12] = mk(4, 1, 6, 1,  4, 1, 0,  0, 0,  6, 1,  0, 2'b10, 2'b11, 0, 0, 0);
    vecs[13] = mk(0, 1, 0, 1,  0, 1, 1,  0, 1,  0, 0,  0, 2'b00, 2'b00, 0, 0, 0);
    vecs[14] = mk(9, 1, 0, 0,  9, 1, 1,  0, 0,  0, 0,  0, 2'b00, 2'b00, 1, 0, 1);

    // Reset: forwarding follows inputs, sequencer stall masked, counter cleared.
    idle();
    rst = 1;
    next_cycle();
    next_cycle();
    d_rs = 3; d_use_rs = 1; e_rd = 3; e_wreg = 1; e_mdu = 1;
    #1;
    check("reset_stall_masked", stall, 0);
    check("reset_fwd_follows", fwd_a, 2'b10);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_sat_stall_cnt", s_stall_cnt, 0);
    check("reset_mdu_done", mdu_done, 0);
    idle();
    next_cycle();
    rst = 0;

    // Combinational vector table, each applied for one cycle and removed
    // before the next edge so no stall is ever clocked into the counter.
    foreach (vecs[i]) begin
      d_rs = vecs[i].rs; d_use_rs = vecs[i].urs; d_rt = vecs[i].rt; d_use_rt = vecs[i].urt;
      e_rd = vecs[i].erd; e_wreg = vecs[i].ewr; e_load = vecs[i].eld;
      m_rd = vecs[i].mrd; m_wreg = vecs[i].mwr; w_rd = vecs[i].wrd; w_wreg = vecs[i].wwr;
      m_taken = vecs[i].mt;
      #1;
      check($sformatf("vec%0d_fwd_a", i), fwd_a, vecs[i].fa);
      check($sformatf("vec%0d_fwd_b", i), fwd_b, vecs[i].fb);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].st);
      check($sformatf("vec%0d_flush_d", i), flush_d, vecs[i].fd);
      check($sformatf("vec%0d_flush_e", i), flush_e, vecs[i].fe);
      idle();
      next_cycle();
    end
    check("table_stall_cnt", stall_cnt, 0);

    // Load-use held for one cycle.
    set_load_use();
    #1;
    check("ld_use_stall", stall, 1);
    check("ld_use_flush_e", flush_e, 1);
    check("ld_use_fwd_b_not_ex", fwd_b, 2'b00);
    next_cycle();
    idle();
    #1;
    check("ld_use_released", stall, 0);
    check("ld_use_stall_cnt", stall_cnt, 1);

    // Single multi-cycle op: 4 stall cycles, then one MduDone cycle.
    next_cycle();
    e_mdu = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("mdu_k%0d_stall", k), stall, (k < 4));
      check($sformatf("mdu_k%0d_done", k), mdu_done, (k == 4));
      next_cycle();
      if (k == 4) e_mdu = 0;
    end
    check("mdu_stall_cnt", stall_cnt, 5);

    // Taken branch on the 2nd BUSY cycle aborts the op.
    e_mdu = 1;
    #1; check("abort_run_stall", stall, 1);
    next_cycle();
    #1; check("abort_busy1_stall", stall, 1);
    next_cycle();
    m_taken = 1;
    #1;
    check("abort_stall", stall, 0);
    check("abort_flush_d", flush_d, 1);
    check("abort_flush_e", flush_e, 1);
    check("abort_done", mdu_done, 0);
    next_cycle();
    e_mdu = 0; m_taken = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("abort_after%0d_stall", k), stall, 0);
      check($sformatf("abort_after%0d_done", k), mdu_done, 0);
      next_cycle();
    end
    check("abort_stall_cnt", stall_cnt, 7);

    // Two back-to-back multi-cycle ops with E_Mdu held high throughout.
    e_mdu = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("b2b_k%0d_stall", k), stall, ((k % 5) != 4));
      check($sformatf("b2b_k%0d_done", k), mdu_done, ((k % 5) == 4));
      next_cycle();
      if (k == 9) e_mdu = 0;
    end
    #1;
    check("b2b_idle_stall", stall, 0);
    check("b2b_stall_cnt", stall_cnt, 15);

    // Saturation: 10 stalled cycles on a 3-bit counter hold at 7.
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    #1;
    check("sat_reset_cnt", s_stall_cnt, 0);
    check("sat_reset_wide_cnt", stall_cnt, 0);
    set_load_use();
    repeat (10) next_cycle();
    idle();
    #1;
    check("sat_cnt_held", s_stall_cnt, 7);
    check("sat_wide_cnt", stall_cnt, 10);

    // Reset in the middle of BUSY abandons the op without MduDone.
    next_cycle();
    e_mdu = 1;
    next_cycle();
    next_cycle();
    rst = 1;
    #1;
    check("rst_busy_stall_masked", stall, 0);
    next_cycle();
    rst = 0; e_mdu = 0;
    #1;
    check("rst_busy_stall_cnt", stall_cnt, 0);
    check("rst_busy_sat_cnt", s_stall_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rst_after%0d_done", k), mdu_done, 0);
      check($sformatf("rst_after%0d_stall", k), stall, 0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning):
- REG_AW, 5: register-address width.
- MDU_LAT, 4: multi-cycle (mul/div) stall cycles; legal values are 2 or more.
- CNT_W, 16: stall performance-counter width.
REQ-003 Ports (name, direction, width, meaning):
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- D_Rs, D_Rt  in  REG_AW  decode-stage source registers
- D_UseRs, D_UseRt  in  1  source actually read
- E_Rd, M_Rd, W_Rd  in  REG_AW  destinations in EX/MEM/WB
- E_Wreg, M_Wreg, W_Wreg  in  1  stage writes a register
- E_Load  in  1  EX instruction is a load
- E_Mdu  in  1  EX instruction is a multi-cycle op
- M_Taken  in  1  branch/jump resolved taken in MEM
- FwdA, FwdB  out  2  operand source: 00 regfile, 01 MEM, 10 EX, 11 WB
- Stall  out  1  freeze PC, IF/ID, ID/EX
- Flush_D, Flush_E  out  1  bubble IF/ID, ID/EX
- MduDone  out  1  one-cycle pulse when the multi-cycle op releases
- StallCnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-004 Forwarding SHALL be combinational per operand, with priority EX > MEM > WB.
REQ-005 An operand SHALL match a stage only if the operand's Use bit is 1, the register is nonzero, the addresses are equal and the stage's Wreg is 1.
REQ-006 An EX match with E_Load=1 SHALL NOT select 10; MEM or WB is considered instead.
REQ-007 Load-use (ld_use) SHALL be ld_use = E_Load & E_Wreg & (E_Rd != 0) & (an Rs or Rt match with EX).
REQ-008 On ld_use, Stall and Flush_E SHALL both be 1 in the same cycle; the condition lasts exactly one cycle because the load advances to MEM.
REQ-009 The FSM states SHALL be RUN, BUSY and DONE; a down-counter cnt SHALL be ceil(log2(MDU_LAT)) bits wide.
REQ-010 In RUN with E_Mdu=1 and M_Taken=0: Stall=1, cnt is loaded with MDU_LAT-1, and the next state is BUSY.
REQ-011 In BUSY: Stall=1 and cnt decrements; when cnt==1 the next state is DONE.
REQ-012 The total multi-cycle stall SHALL be exactly MDU_LAT cycles.
REQ-013 In DONE: MduDone=1, Stall comes from ld_use only, E_Mdu is ignored, and the next state is RUN.
REQ-014 A back-to-back multi-cycle op SHALL be accepted on the RUN cycle after DONE.
REQ-015 M_Taken=1 SHALL force Flush_D=1 and Flush_E=1, force Stall=0 and abort BUSY to RUN with cnt=0 and no MduDone, because the EX op is younger and is squashed.
REQ-016 M_Taken SHALL take priority over ld_use and over the multi-cycle stall.
REQ-017 Stall SHALL be (ld_use | FSM stall) & ~M_Taken, and Flush_E SHALL be ld_use | M_Taken.
REQ-018 StallCnt SHALL increment on each cycle with Stall=1 and saturate at all-ones, with no wrap.

Reset
REQ-019 While Rst=1 at a clock edge: state=RUN, cnt=0, StallCnt=0.
REQ-020 Reset during BUSY SHALL abandon the op with no MduDone pulse.
REQ-021 The combinational outputs SHALL follow their inputs during reset, except the FSM-derived Stall, which SHALL be 0.

Structure
REQ-022 The shared package hazard_pkg SHALL hold the state enum {RUN, BUSY, DONE} and the FWD_REG/FWD_MEM/FWD_EX/FWD_WB encodings.
REQ-023 One sub-module, hz_fwd_sel, SHALL implement per-operand forwarding selection and be instantiated twice (Rs and Rt).
REQ-024 The FSM, counter and StallCnt SHALL reside in hazard_ctrl.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- D_Rs=3, E_Rd=3, E_Wreg=1, E_Load=0, M_Rd=3, M_Wreg=1 -> FwdA=10. Then E_Wreg=0 -> FwdA=01. Then D_Rs=0 -> FwdA=00.
- E_Load=1, E_Rd=5, D_Rt=5, D_UseRt=1 -> Stall=1 and Flush_E=1 for one cycle; FwdB is not 10; StallCnt +1.
- MDU_LAT=4, E_Mdu pulse in RUN -> Stall high for exactly 4 cycles, then MduDone high for 1 cycle; StallCnt +4.
- M_Taken=1 on the 2nd BUSY cycle -> Flush_D=Flush_E=1 and Stall=0 that cycle; next state RUN; no MduDone ever.
- Two multi-cycle ops back-to-back -> 4 stall cycles, DONE, 4 stall cycles, DONE, with no lost or merged op.
- CNT_W=3 and 10 stall cycles -> StallCnt holds at 7. Rst mid-BUSY -> StallCnt=0, RUN, no MduDone.
